// File: rtl/lif_spike_rate_decoder_if.sv
// rtl/lif_spike_rate_decoder_if.sv - per-channel count stream between decoder and readout
interface lif_spike_rate_decoder_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;

    modport master (
        output out_valid,
        output out_ch,
        output out_count,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ch,
        input  out_count,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/lif_spike_rate_decoder.sv
// rtl/lif_spike_rate_decoder.sv - windowed spike counting, snapshot, argmax and count streaming
module lif_spike_rate_decoder #(
    parameter  int N_CH  = 8,
    parameter  int CNT_W = 8,
    parameter  int WIN_W = 16,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIN_W-1:0]              win_len,
    input  logic [N_CH-1:0]               spike_in,
    lif_spike_rate_decoder_if.master      out_if,
    output logic [CH_W-1:0]               winner,
    output logic                          winner_valid,
    output logic                          overrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic              load_snap;

    logic [N_CH-1:0]   spike_q;
    logic [N_CH-1:0]   spike_edge;
    logic [CNT_W-1:0]  cnt_q   [N_CH];
    logic [CNT_W-1:0]  cnt_nxt [N_CH];
    logic [CNT_W-1:0]  snap_q  [N_CH];

    logic [WIN_W-1:0]  wcnt_q;
    logic [WIN_W-1:0]  len_q;
    logic [WIN_W-1:0]  cur_len;
    logic              win_end;

    logic [CNT_W-1:0]  best_cnt;
    logic [CH_W-1:0]   best_idx;

    assign spike_edge = spike_in & ~spike_q;

    // At wcnt==0 the length register is being loaded this edge, so compare against the live input.
    assign cur_len = (wcnt_q == '0) ? ((win_len == '0) ? WIN_W'(1) : win_len) : len_q;
    assign win_end = en && (wcnt_q == cur_len - WIN_W'(1));

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = (spike_edge[i] && (cnt_q[i] != '1)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_cnt = cnt_nxt[0];
        best_idx = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (cnt_nxt[i] > best_cnt) begin
                best_cnt = cnt_nxt[i];
                best_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_snap = 1'b0;
        out_if.out_valid = 1'b0;
        out_if.out_ch    = idx_q;
        out_if.out_count = snap_q[idx_q];
        out_if.out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_end) begin
                    load_snap = 1'b1;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                out_if.out_valid = 1'b1;
                out_if.out_last  = (idx_q == CH_W'(N_CH - 1));
                if (out_if.out_ready) begin
                    if (idx_q == CH_W'(N_CH - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q      <= '0;
            wcnt_q       <= '0;
            len_q        <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            spike_q <= spike_in;
            if (en) begin
                if (wcnt_q == '0) begin
                    len_q <= cur_len;
                end
                if (win_end) begin
                    wcnt_q <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    wcnt_q <= wcnt_q + WIN_W'(1);
                    for (int i = 0; i < N_CH; i++) begin
                        cnt_q[i] <= cnt_nxt[i];
                    end
                end
            end
            if (load_snap) begin
                winner       <= best_idx;
                winner_valid <= (best_cnt != '0);
                for (int i = 0; i < N_CH; i++) begin
                    snap_q[i] <= cnt_nxt[i];
                end
            end else if (win_end) begin
                // Stream still busy: this window's counts are lost.
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// tb/tb_lif_spike_rate_decoder.sv - scoreboard bench for lif_spike_rate_decoder
module tb_lif_spike_rate_decoder;

    localparam int N_CH  = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] cnt;
        logic       last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIN_W-1:0] win_len;
    logic [N_CH-1:0]  spike_in;
    logic [2:0]       winner;
    logic             winner_valid;
    logic             overrun;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t mon_exp;
    beat_t mon_obs;

    lif_spike_rate_decoder_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    lif_spike_rate_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .win_len      (win_len),
        .spike_in     (spike_in),
        .out_if       (bus.master),
        .winner       (winner),
        .winner_valid (winner_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [N_CH-1:0] s, input logic e);
        spike_in = s;
        en       = e;
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input int cnts[N_CH]);
        for (int i = 0; i < N_CH; i++) begin
            exp_q.push_back('{ch: 3'(i), cnt: 8'(cnts[i]), last: (i == N_CH - 1)});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            chk("beat_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_obs = '{ch: bus.out_ch, cnt: bus.out_count, last: bus.out_last};
                chk("beat", mon_obs, mon_exp);
            end
        end
    end

    initial begin
        int e[N_CH];
        logic [N_CH-1:0] s;

        rst = 1'b1; en = 1'b0; win_len = '0; spike_in = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_beat", {bus.out_ch, bus.out_count, bus.out_last}, 0);
        chk("reset_winner", {winner, winner_valid, overrun}, 0);
        rst = 1'b0;

        // Basic window: ch3 four pulses, ch0 held high from cycle 2
        win_len = 10; bus.out_ready = 1'b1;
        e = '{1, 0, 0, 4, 0, 0, 0, 0}; push_stream(e);
        for (int c = 0; c < 10; c++) begin
            s = '0;
            if (c >= 2) s[0] = 1'b1;
            if (c == 1 || c == 3 || c == 5 || c == 7) s[3] = 1'b1;
            cyc(s, 1'b1);
        end
        chk("basic_latency", bus.out_valid, 1);
        chk("basic_winner", {winner, winner_valid}, {3'd3, 1'b1});
        cyc(8'h01, 1'b0);
        cyc(8'h00, 1'b0);
        drain();

        // Saturation: ch5 toggles every cycle for 600 cycles
        win_len = 600;
        e = '{0, 0, 0, 0, 0, 255, 0, 0}; push_stream(e);
        for (int c = 0; c < 600; c++) begin
            s = '0;
            s[5] = c[0];
            cyc(s, 1'b1);
        end
        chk("sat_winner", {winner, winner_valid}, {3'd5, 1'b1});
        cyc(8'h00, 1'b0);
        drain();

        // Backpressure across two window ends
        win_len = 8; bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) cyc((c == 2) ? 8'h02 : 8'h00, 1'b1);
        chk("bp_valid", bus.out_valid, 1);
        for (int c = 0; c < 8; c++) begin
            cyc((c == 1 || c == 3 || c == 5) ? 8'h04 : 8'h00, 1'b1);
            chk("bp_hold", {bus.out_valid, bus.out_ch, bus.out_count, bus.out_last}, {1'b1, 12'h000});
        end
        chk("bp_overrun", overrun, 1);
        chk("bp_winner_kept", {winner, winner_valid}, {3'd1, 1'b1});
        e = '{0, 1, 0, 0, 0, 0, 0, 0}; push_stream(e);
        bus.out_ready = 1'b1;
        cyc(8'h00, 1'b0);
        drain();

        // Tie between ch2 and ch6, then an all-zero window
        win_len = 10;
        e = '{0, 0, 3, 0, 0, 0, 3, 0}; push_stream(e);
        for (int c = 0; c < 10; c++) cyc((c == 1 || c == 3 || c == 5) ? 8'h44 : 8'h00, 1'b1);
        chk("tie_winner", {winner, winner_valid}, {3'd2, 1'b1});
        cyc(8'h00, 1'b0);
        drain();
        e = '{0, 0, 0, 0, 0, 0, 0, 0}; push_stream(e);
        for (int c = 0; c < 10; c++) cyc(8'h00, 1'b1);
        chk("zero_winner", {winner, winner_valid}, {3'd0, 1'b0});
        cyc(8'h00, 1'b0);
        drain();

        // win_len=0 closes a window on a single enabled cycle
        win_len = 0;
        e = '{0, 0, 0, 0, 0, 0, 0, 1}; push_stream(e);
        cyc(8'h80, 1'b1);
        chk("len0_valid", bus.out_valid, 1);
        chk("len0_winner", {winner, winner_valid}, {3'd7, 1'b1});
        cyc(8'h00, 1'b0);
        drain();

        // en gating: five frozen cycles with toggling input, length latched at start
        win_len = 6;
        e = '{0, 2, 0, 0, 0, 0, 0, 0}; push_stream(e);
        cyc(8'h00, 1'b1);
        win_len = 2;
        cyc(8'h02, 1'b1);
        cyc(8'h00, 1'b0); cyc(8'h02, 1'b0); cyc(8'h00, 1'b0); cyc(8'h02, 1'b0); cyc(8'h00, 1'b0);
        cyc(8'h02, 1'b1);
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        chk("gate_no_early_end", bus.out_valid, 0);
        cyc(8'h00, 1'b1);
        chk("gate_end", bus.out_valid, 1);
        chk("gate_winner", {winner, winner_valid}, {3'd1, 1'b1});
        cyc(8'h00, 1'b0);
        drain();

        // Asynchronous reset mid-stream, then restart from wcnt=0
        win_len = 4; bus.out_ready = 1'b0;
        cyc(8'h10, 1'b1); cyc(8'h00, 1'b1); cyc(8'h00, 1'b1); cyc(8'h00, 1'b1);
        chk("pre_reset_valid", bus.out_valid, 1);
        spike_in = 8'hAA;
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", bus.out_valid, 0);
        chk("async_reset_outs", {winner, winner_valid, overrun, bus.out_count, bus.out_last}, 0);
        @(posedge clk);
        #1;
        spike_in = 8'h00;
        rst = 1'b0;
        win_len = 3; bus.out_ready = 1'b1;
        e = '{0, 0, 0, 0, 0, 0, 1, 0}; push_stream(e);
        cyc(8'h40, 1'b1);
        cyc(8'h00, 1'b1);
        chk("restart_no_early_end", bus.out_valid, 0);
        cyc(8'h00, 1'b1);
        chk("restart_end", bus.out_valid, 1);
        chk("restart_winner", {winner, winner_valid, overrun}, {3'd6, 1'b1, 1'b0});
        cyc(8'h00, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
